// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and types for the 7-segment scan controller
// Contents: digit count, active-low segment glyphs {a,b,c,d,e,f,g}, scan FSM states.
package seg7_pkg;

    localparam int N_DIGITS = 4;

    // Active-low glyphs, bit order {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001101;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seg7_bcd_decode.sv
// rtl/seg7_bcd_decode.sv - combinational BCD nibble to active-low 7-segment glyph
// Ports:
//   i_bcd  in  4  BCD nibble; 10..15 decode to all segments off
//   o_seg  out 7  active-low segments {a,b,c,d,e,f,g}
module seg7_bcd_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - 4-digit common-anode 7-segment scan controller with shadow-buffered load
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (blank leading zeros on digits 3..1).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   enable          scan enable; low keeps the display dark
//   load_valid/ready handshake for a new value; ready = pending buffer empty
//   load_bcd[15:0]  nibble i drives digit i (digit 0 rightmost)
//   load_dp[3:0]    decimal point per digit, 1 = lit
//   digit[3:0]      active-low digit enables, at most one low
//   Seven_Segment   active-low {a,b,c,d,e,f,g,dp}
//   frame_done      one-cycle pulse at the end of each 4-digit frame
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int REFRESH_HZ   = 1000,
    parameter int BLANK_CYCLES = 64
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*N_DIGITS-1:0] load_bcd,
    input  logic [N_DIGITS-1:0]   load_dp,
    output logic [N_DIGITS-1:0]   digit,
    output logic [7:0]            Seven_Segment,
    output logic                  frame_done
);

    localparam int SLOT  = CLK_HZ / REFRESH_HZ;
    localparam int DWELL = SLOT - BLANK_CYCLES;
    localparam int CNT_W = $clog2(SLOT);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    scan_state_t           r_state;
    logic [1:0]            r_idx;
    logic [CNT_W-1:0]      r_cnt;
    logic [4*N_DIGITS-1:0] r_active_bcd;
    logic [N_DIGITS-1:0]   r_active_dp;
    logic [4*N_DIGITS-1:0] r_pend_bcd;
    logic [N_DIGITS-1:0]   r_pend_dp;
    logic                  r_pend_full;
    logic [N_DIGITS-1:0]   r_digit;
    logic [7:0]            r_seg;
    logic                  r_frame_done;

    logic       w_load_fire;
    logic       w_frame_end;
    logic       w_apply;
    logic [3:0] w_nibble;
    logic [6:0] w_decoded;
    logic [6:0] w_glyph;
    logic       w_lz_blank;

    assign load_ready    = ~r_pend_full;
    assign digit         = r_digit;
    assign Seven_Segment = r_seg;
    assign frame_done    = r_frame_done;

    assign w_load_fire = load_valid & ~r_pend_full;
    // Last BLANK cycle of digit 3; a falling enable in the same cycle wins.
    assign w_frame_end = enable && (r_state == BLANK) && (r_idx == 2'd3) && (r_cnt == BLANK_LAST);
    // While idle nothing is driven, so a pending value can go live immediately.
    assign w_apply     = r_pend_full && (w_frame_end || (r_state == IDLE));

    assign w_nibble = r_active_bcd[{r_idx, 2'b00} +: 4];

    seg7_bcd_decode u_decode (
        .i_bcd (w_nibble),
        .o_seg (w_decoded)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Blank a digit when it and every more-significant nibble are zero; digit 0 always shows.
    always_comb begin
        w_lz_blank = 1'b0;
        case (r_idx)
            2'd3:    w_lz_blank = (r_active_bcd[15:12] == 4'd0);
            2'd2:    w_lz_blank = (r_active_bcd[15:8]  == 8'd0);
            2'd1:    w_lz_blank = (r_active_bcd[15:4]  == 12'd0);
            default: w_lz_blank = 1'b0;
        endcase
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    assign w_glyph = w_lz_blank ? SEG_BLANK : w_decoded;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= 2'd0;
            r_cnt        <= '0;
            r_active_bcd <= '0;
            r_active_dp  <= '0;
            r_pend_bcd   <= '0;
            r_pend_dp    <= '0;
            r_pend_full  <= 1'b0;
            r_digit      <= '1;
            r_seg        <= 8'hFF;
            r_frame_done <= 1'b0;
        end else begin
            // Capture and apply are exclusive: capture needs the buffer empty.
            if (w_load_fire) begin
                r_pend_bcd  <= load_bcd;
                r_pend_dp   <= load_dp;
                r_pend_full <= 1'b1;
            end else if (w_apply) begin
                r_active_bcd <= r_pend_bcd;
                r_active_dp  <= r_pend_dp;
                r_pend_full  <= 1'b0;
            end

            r_frame_done <= w_frame_end;

            if (!enable) begin
                r_state <= IDLE;
                r_idx   <= 2'd0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= DRIVE;
                        r_idx   <= 2'd0;
                        r_cnt   <= '0;
                    end
                    DRIVE: begin
                        if (r_cnt == DWELL_LAST) begin
                            r_state <= BLANK;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    BLANK: begin
                        if (r_cnt == BLANK_LAST) begin
                            r_state <= DRIVE;
                            r_cnt   <= '0;
                            r_idx   <= r_idx + 2'd1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_idx   <= 2'd0;
                        r_cnt   <= '0;
                    end
                endcase
            end

            // Outputs trail the state by one register stage.
            if (r_state == DRIVE) begin
                r_digit <= ~(4'b0001 << r_idx);
                r_seg   <= {w_glyph, ~r_active_dp[r_idx]};
            end else begin
                r_digit <= '1;
                r_seg   <= 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - randomized self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

    localparam int CLK_HZ       = 1000;
    localparam int REFRESH_HZ   = 100;
    localparam int BLANK_CYCLES = 2;
    localparam int SLOT         = CLK_HZ / REFRESH_HZ;
    localparam int DWELL        = SLOT - BLANK_CYCLES;
    localparam int FRAME        = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_bcd = '0;
    logic [3:0]  load_dp = '0;
    logic [3:0]  digit;
    logic [7:0]  Seven_Segment;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    // Reference model: scan position counted in cycles since scanning began
    bit          m_scan;
    int          m_k;
    logic [15:0] m_act_bcd, m_pend_bcd;
    logic [3:0]  m_act_dp, m_pend_dp;
    bit          m_pf;

    seg7_scan_ctrl #(
        .CLK_HZ       (CLK_HZ),
        .REFRESH_HZ   (REFRESH_HZ),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_bcd      (load_bcd),
        .load_dp       (load_dp),
        .digit         (digit),
        .Seven_Segment (Seven_Segment),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001101;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(input int slot);
        logic [6:0] s;
        s = glyph(m_act_bcd[slot*4 +: 4]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (slot > 0 && (m_act_bcd >> (4 * slot)) == 16'd0) s = 7'b1111111;
`endif
        return {s, ~m_act_dp[slot]};
    endfunction

    task automatic model_reset();
        m_scan = 0; m_k = 0; m_pf = 0;
        m_act_bcd = '0; m_act_dp = '0; m_pend_bcd = '0; m_pend_dp = '0;
    endtask

    // One clock: sample inputs at the edge, advance the model, check outputs 1 time unit later
    task automatic cycle();
        bit          en_s, lv_s, e_fd;
        logic [15:0] b_s;
        logic [3:0]  d_s, e_dig;
        logic [7:0]  e_seg;
        @(posedge clk);
        en_s = enable; lv_s = load_valid; b_s = load_bcd; d_s = load_dp;
        e_dig = 4'hF; e_seg = 8'hFF; e_fd = 0;
        if (m_scan) begin
            int pos, slot;
            pos  = m_k % SLOT;
            slot = (m_k / SLOT) % 4;
            if (pos < DWELL) begin
                e_dig = ~(4'b0001 << slot);
                e_seg = exp_seg(slot);
            end
            e_fd = en_s && (m_k % FRAME == FRAME - 1);
        end
        if (lv_s && !m_pf) begin
            m_pend_bcd = b_s; m_pend_dp = d_s; m_pf = 1;
        end else if (m_pf && (!m_scan || e_fd)) begin
            m_act_bcd = m_pend_bcd; m_act_dp = m_pend_dp; m_pf = 0;
        end
        if (!en_s) begin
            m_scan = 0;
        end else if (!m_scan) begin
            m_scan = 1; m_k = 0;
        end else begin
            m_k++;
        end
        #1;
        check("digit", 32'(digit), 32'(e_dig));
        check("seg", 32'(Seven_Segment), 32'(e_seg));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("load_ready", 32'(load_ready), 32'(!m_pf));
    endtask

    task automatic load_one(input logic [15:0] bcd, input logic [3:0] dp);
        load_valid = 1; load_bcd = bcd; load_dp = dp;
        cycle();
        load_valid = 0;
    endtask

    task automatic check_reset_state();
        check("rst_digit", 32'(digit), 32'h0000000F);
        check("rst_seg", 32'(Seven_Segment), 32'h000000FF);
        check("rst_ready", 32'(load_ready), 32'h1);
        check("rst_frame_done", 32'(frame_done), 32'h0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        rst_n = 1;

        repeat (3) cycle();
        enable = 1;
        repeat (90) cycle();

        load_one(16'h1234, 4'b0100);
        repeat (90) cycle();

        load_valid = 1; load_bcd = 16'h5678; load_dp = 4'b0001;
        cycle();
        load_bcd = 16'h9870; load_dp = 4'b1000;
        repeat (50) cycle();
        load_valid = 0;
        repeat (40) cycle();

        load_one(16'h00B0, 4'b0010);
        repeat (90) cycle();

        repeat (23) cycle();
        enable = 0;
        repeat (4) cycle();
        enable = 1;
        repeat (60) cycle();

        load_one(16'h0050, 4'b0000);
        repeat (90) cycle();

        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            load_valid = ($urandom_range(0, 9) == 0);
            load_bcd   = 16'($urandom);
            if ($urandom_range(0, 2) == 0) load_bcd = load_bcd >> (4 * $urandom_range(1, 3));
            load_dp    = 4'($urandom);
            cycle();
        end
        load_valid = 0;
        enable = 1;
        repeat (30) cycle();

        load_one(16'h4321, 4'b1111);
        repeat (7) cycle();
        rst_n = 0;
        #2;
        check_reset_state();
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        repeat (90) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
